// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the two-master APB arbiter.
package apb_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin pick, purely combinational (zero latency, no backpressure).
// On a tie the port that did not win last time is chosen.
module apb_rr_arbiter
  import apb_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_vld,
  output logic grant
);

  assign grant_vld = req0 | req1;
  assign grant     = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/apb_arbiter.sv
// Shares one downstream APB master port between two upstream APB masters.
// Adds one SETUP cycle per transfer; upstream masters are stalled (pready=0) until served.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              s0_psel,
  input  logic              s0_penable,
  input  logic              s0_pwrite,
  input  logic [ADDR_W-1:0] s0_paddr,
  input  logic [DATA_W-1:0] s0_pwdata,
  output logic              s0_pready,
  output logic [DATA_W-1:0] s0_prdata,
  output logic              s0_pslverr,

  input  logic              s1_psel,
  input  logic              s1_penable,
  input  logic              s1_pwrite,
  input  logic [ADDR_W-1:0] s1_paddr,
  input  logic [DATA_W-1:0] s1_pwdata,
  output logic              s1_pready,
  output logic [DATA_W-1:0] s1_prdata,
  output logic              s1_pslverr,

  output logic              m_psel,
  output logic              m_penable,
  output logic              m_pwrite,
  output logic [ADDR_W-1:0] m_paddr,
  output logic [DATA_W-1:0] m_pwdata,
  input  logic              m_pready,
  input  logic [DATA_W-1:0] m_prdata,
  input  logic              m_pslverr
);

  state_e            state, state_nxt;
  logic              grant_q, grant_nxt;
  logic              last_q, last_nxt;
  logic              write_q, write_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;

  logic              in_access;
  logic              arb_req0, arb_req1, arb_last;
  logic              arb_vld, arb_grant;
  logic              sel0, sel1;

  // Arbitration ignores upstream penable; only psel marks a pending request.
  logic              unused_penable;
  assign unused_penable = s0_penable ^ s1_penable;

  assign in_access = (state == ACCESS);

  // In the completion cycle the finishing port still shows psel, so it is masked out.
  assign arb_req0 = s0_psel & ~(in_access & ~grant_q);
  assign arb_req1 = s1_psel & ~(in_access &  grant_q);
  assign arb_last = in_access ? grant_q : last_q;

  apb_rr_arbiter u_rr (
    .req0       (arb_req0),
    .req1       (arb_req1),
    .last_grant (arb_last),
    .grant_vld  (arb_vld),
    .grant      (arb_grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
      write_q <= write_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    last_nxt  = last_q;
    write_nxt = write_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    case (state)
      IDLE: begin
        if (arb_vld) begin
          state_nxt = SETUP;
          grant_nxt = arb_grant;
          write_nxt = arb_grant ? s1_pwrite : s0_pwrite;
          addr_nxt  = arb_grant ? s1_paddr  : s0_paddr;
          wdata_nxt = arb_grant ? s1_pwdata : s0_pwdata;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (m_pready) begin
          last_nxt = grant_q;
          if (arb_vld) begin
            state_nxt = SETUP;
            grant_nxt = arb_grant;
            write_nxt = arb_grant ? s1_pwrite : s0_pwrite;
            addr_nxt  = arb_grant ? s1_paddr  : s0_paddr;
            wdata_nxt = arb_grant ? s1_pwdata : s0_pwdata;
          end else begin
            state_nxt = IDLE;
            write_nxt = 1'b0;
            addr_nxt  = '0;
            wdata_nxt = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request registers are cleared on return to IDLE, so they drive the bus directly.
  assign m_psel    = (state != IDLE);
  assign m_penable = in_access;
  assign m_pwrite  = write_q;
  assign m_paddr   = addr_q;
  assign m_pwdata  = wdata_q;

  assign sel0 = (state != IDLE) & ~grant_q;
  assign sel1 = (state != IDLE) &  grant_q;

  assign s0_pready  = sel0 & in_access & m_pready;
  assign s0_pslverr = sel0 & in_access & m_pslverr & m_pready;
  assign s0_prdata  = sel0 ? m_prdata : '0;

  assign s1_pready  = sel1 & in_access & m_pready;
  assign s1_pslverr = sel1 & in_access & m_pslverr & m_pready;
  assign s1_prdata  = sel1 ? m_prdata : '0;

endmodule
